// File: rtl/dsp_mac_sequencer.sv
// Streams 18x18 operand pairs into one MULTALU18X18 (mode 0, C/D = 0) as a MAC; optional out_ovf via `DSP_MAC_OVF_EN.
// Result valid DSP_LAT+1 cycles after the last accept; in_ready drops in DRAIN/HOLD until out_valid&out_ready.
module dsp_mac_sequencer #(
    parameter int DSP_LAT   = 1,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_signed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [53:0]      out_data,
    output logic [CNT_W-1:0] out_count,
`ifdef DSP_MAC_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic             dsp_asign,
    output logic             dsp_bsign,
    output logic             dsp_accload,
    output logic             dsp_ce,
    input  logic [53:0]      dsp_dout
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic [2:0]       r_drain;
    logic [53:0]      r_out_data;
    logic [CNT_W-1:0] r_out_count;
    logic             r_out_valid;

    logic             w_in_phase;
    logic             w_accept;
    logic             w_drain_ce;
    logic             w_final;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Reset gates the combinational DSP controls so nothing is clocked into the DSP while it is held in reset.
    assign w_in_phase = !reset && (r_state == IDLE || r_state == ACCUM);
    assign w_accept   = in_valid && w_in_phase;
    assign w_drain_ce = !reset && (r_state == DRAIN) && (r_drain != 3'd0);
    assign w_cnt_nxt  = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_final    = in_last || (w_cnt_nxt == CNT_W'(MAX_TERMS));

    assign in_ready    = w_in_phase;
    assign dsp_a       = w_in_phase ? in_a : 18'd0;
    assign dsp_b       = w_in_phase ? in_b : 18'd0;
    assign dsp_ce      = w_accept || w_drain_ce;
    assign dsp_accload = !reset && (r_state == ACCUM || r_state == DRAIN);
    assign dsp_asign   = (r_state == IDLE) ? cfg_signed : r_sign;
    assign dsp_bsign   = (r_state == IDLE) ? cfg_signed : r_sign;
    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_count   = r_out_count;

`ifdef DSP_MAC_OVF_EN
    logic r_ovf;
    assign out_ovf = r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_drain     <= 3'd0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_valid <= 1'b0;
`ifdef DSP_MAC_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_nxt;
                        if (r_state == IDLE) r_sign <= cfg_signed;
                        if (w_final) begin
                            r_state <= DRAIN;
                            r_drain <= 3'(DSP_LAT - 1);
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                DRAIN: begin
                    // Zero terms push the last product through the input registers before capture.
                    if (r_drain != 3'd0) begin
                        r_drain <= r_drain - 3'd1;
                    end else begin
                        r_out_data  <= dsp_dout;
                        r_out_count <= r_cnt;
                        r_out_valid <= 1'b1;
`ifdef DSP_MAC_OVF_EN
                        r_ovf       <= (dsp_dout[53:35] != {19{dsp_dout[35]}});
`endif
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
